// File: rtl/pkt_frame_tracker.sv
// pkt_frame_tracker
//   Tracks head/tail framing on CHANNELS independent beat streams. Each
//   channel runs its own small FSM (IDLE, HEAD, DATA, TAIL, ERR). The FSM
//   counts beats, reports completed packets and their length, and flags
//   framing errors: stray tail, nested head and overlength.
//
// Handshake: there is no backpressure. A beat on channel i is taken in any
//   cycle where valid[i] is high. head[i] and tail[i] are markers that only
//   mean something while valid[i] is high.
//
// Ports
//   clk       : single clock, all state changes on its rising edge
//   reset     : asynchronous, active-high reset of every channel
//   clear     : synchronous clear of every channel (state, counters, length)
//   valid     : [CHANNELS]        per-channel beat valid
//   head      : [CHANNELS]        per-channel first-beat marker
//   tail      : [CHANNELS]        per-channel last-beat marker
//   state     : [3*CHANNELS]      per-channel registered FSM state
//                                 (IDLE=0 HEAD=1 DATA=2 TAIL=3 ERR=4)
//   pkt_done  : [CHANNELS]        high while a channel sits in TAIL
//   err       : [CHANNELS]        high in the first cycle a channel sits in ERR
//   last_len  : [LEN_W*CHANNELS]  beat count of the last good packet
//   pkt_cnt   : [CNT_W*CHANNELS]  saturating count of good packets
module pkt_frame_tracker #(
    parameter int CHANNELS    = 2,
    parameter int LEN_W       = 4,
    parameter int MAX_BEATS   = 8,
    parameter int CNT_W       = 8,
    parameter int SINGLE_BEAT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       valid,
    input  logic [CHANNELS-1:0]       head,
    input  logic [CHANNELS-1:0]       tail,
    output logic [3*CHANNELS-1:0]     state,
    output logic [CHANNELS-1:0]       pkt_done,
    output logic [CHANNELS-1:0]       err,
    output logic [LEN_W*CHANNELS-1:0] last_len,
    output logic [CNT_W*CHANNELS-1:0] pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HEAD = 3'd1,
        S_DATA = 3'd2,
        S_TAIL = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic             SB      = (SINGLE_BEAT != 0);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           cur_q;
        state_t           nxt;
        logic [LEN_W-1:0] beat_q;
        logic [LEN_W-1:0] beat_nxt;
        logic [LEN_W-1:0] beat_inc;
        logic [LEN_W-1:0] len_q;
        logic [LEN_W-1:0] done_len;
        logic [CNT_W-1:0] cnt_q;
        logic             done;
        logic             was_err_q;
        logic             v;
        logic             h;
        logic             t;

        assign v        = valid[g];
        assign h        = head[g];
        assign t        = tail[g];
        assign beat_inc = beat_q + LEN_W'(1);

        // done marks an entry into TAIL, the only place a packet counts
        // as good. done_len is the length recorded with it.
        always_comb begin
            nxt      = cur_q;
            beat_nxt = beat_q;
            done     = 1'b0;
            done_len = '0;
            case (cur_q)
                // TAIL behaves like IDLE, so a new head can follow a tail
                // with no gap cycle.
                S_IDLE, S_TAIL: begin
                    if (v && h && t && SB) begin
                        nxt      = S_TAIL;
                        done     = 1'b1;
                        done_len = LEN_W'(1);
                    end else if (v && h) begin
                        nxt      = S_HEAD;
                        beat_nxt = LEN_W'(1);
                    end else if (v && t) begin
                        nxt = S_ERR;
                    end else begin
                        nxt = S_IDLE;
                    end
                end
                S_HEAD, S_DATA: begin
                    if (!v) begin
                        nxt = S_DATA;
                    end else if (h) begin
                        // A nested head wins over a tail on the same beat.
                        nxt = S_ERR;
                    end else if (t) begin
                        nxt      = S_TAIL;
                        done     = 1'b1;
                        done_len = beat_inc;
                    end else if (beat_inc == MAX_LEN) begin
                        // The beat that would reach MAX_BEATS without
                        // closing the packet makes it overlength.
                        nxt = S_ERR;
                    end else begin
                        nxt      = S_DATA;
                        beat_nxt = beat_inc;
                    end
                end
                S_ERR: begin
                    if (v && h) begin
                        if (t && SB) begin
                            nxt      = S_TAIL;
                            done     = 1'b1;
                            done_len = LEN_W'(1);
                        end else begin
                            nxt      = S_HEAD;
                            beat_nxt = LEN_W'(1);
                        end
                    end else begin
                        nxt = S_ERR;
                    end
                end
                default: nxt = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cur_q     <= S_IDLE;
                beat_q    <= '0;
                len_q     <= '0;
                cnt_q     <= '0;
                was_err_q <= 1'b0;
            end else if (clear) begin
                cur_q     <= S_IDLE;
                beat_q    <= '0;
                len_q     <= '0;
                cnt_q     <= '0;
                was_err_q <= 1'b0;
            end else begin
                cur_q     <= nxt;
                beat_q    <= beat_nxt;
                was_err_q <= (cur_q == S_ERR);
                if (done) begin
                    len_q <= done_len;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end

        // All outputs are decodes of flops. err compares the current state
        // with the registered "was in ERR" flag, so it stays high for only
        // the first ERR cycle.
        assign state[3*g +: 3]         = cur_q;
        assign pkt_done[g]             = (cur_q == S_TAIL);
        assign err[g]                  = (cur_q == S_ERR) && !was_err_q;
        assign last_len[LEN_W*g +: LEN_W] = len_q;
        assign pkt_cnt[CNT_W*g +: CNT_W]  = cnt_q;
    end

endmodule

// File: tb/tb_pkt_frame_tracker.sv
// Bench for pkt_frame_tracker.
// There are two instances, one with SINGLE_BEAT=0 and one with SINGLE_BEAT=1,
// and they share every input. Apart from the single-beat test, no scenario
// drives head and tail together, so both instances must behave the same.
// Each expected-output word is {dut1 state,pkt_done,err , dut0 state,pkt_done,err}.
module tb_pkt_frame_tracker;
    localparam int CH = 2;
    localparam int LW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [CH-1:0] valid;
    logic [CH-1:0] head;
    logic [CH-1:0] tail;

    logic [3*CH-1:0]  st0, st1;
    logic [CH-1:0]    pd0, pd1, er0, er1;
    logic [LW*CH-1:0] ll0, ll1;
    logic [CW*CH-1:0] pc0, pc1;

    logic [19:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    pkt_frame_tracker #(.CHANNELS(CH), .LEN_W(LW), .MAX_BEATS(4), .CNT_W(CW), .SINGLE_BEAT(0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .valid(valid), .head(head), .tail(tail),
        .state(st0), .pkt_done(pd0), .err(er0), .last_len(ll0), .pkt_cnt(pc0));

    pkt_frame_tracker #(.CHANNELS(CH), .LEN_W(LW), .MAX_BEATS(4), .CNT_W(CW), .SINGLE_BEAT(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .valid(valid), .head(head), .tail(tail),
        .state(st1), .pkt_done(pd1), .err(er1), .last_len(ll1), .pkt_cnt(pc1));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // s = {valid[1:0], head[1:0], tail[1:0]}; this returns 1 ns after the edge.
    task automatic drive(input logic [5:0] s);
        valid = s[5:4];
        head  = s[3:2];
        tail  = s[1:0];
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] w(input logic [2:0] s0, input logic [2:0] s1,
                                     input logic [1:0] pd, input logic [1:0] er);
        return {s1, s0, pd, er};
    endfunction

    function automatic logic [19:0] obs();
        return {st1, pd1, er1, st0, pd0, er0};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; valid = '0; head = '0; tail = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({st1, st0, pd1, pd0, er1, er0} !== '0) begin
            n_fail++; $display("FAIL reset_state: got %h expected 0", {st1, st0, pd1, pd0, er1, er0});
        end
        n_tests++;
        if ({ll1, ll0, pc1, pc0} !== '0) begin
            n_fail++; $display("FAIL reset_counters: got %h expected 0", {ll1, ll0, pc1, pc0});
        end
        #2 reset = 1'b0;
        exp_q.push_back({w(0, 0, 0, 0), w(0, 0, 0, 0)});
        drive(6'b00_00_00);
        begin
            logic [19:0] e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL reset_release: got %h expected %h", obs(), e);
            end
        end
    endtask

    task automatic test_basic();
        logic [5:0] stim [5];
        logic [9:0] ew [5];
        stim = '{6'b01_01_00, 6'b01_00_00, 6'b01_00_01, 6'b00_00_00, 6'b00_01_01};
        ew   = '{w(1,0,0,0), w(2,0,0,0), w(3,0,1,0), w(0,0,0,0), w(0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({ew[i], ew[i]});
            drive(stim[i]);
            begin
                logic [19:0] e = exp_q.pop_front();
                n_tests++;
                if (obs() !== e) begin
                    n_fail++; $display("FAIL basic beat %0d: got %h expected %h", i, obs(), e);
                end
            end
        end
        n_tests++;
        if ({ll1, ll0, pc1, pc0} !== {8'h03, 8'h03, 8'h01, 8'h01}) begin
            n_fail++; $display("FAIL basic_len_cnt: got %h expected 03030101", {ll1, ll0, pc1, pc0});
        end
    endtask

    task automatic test_nested_head();
        logic [5:0] stim [6];
        logic [9:0] ew [6];
        stim = '{6'b01_01_00, 6'b01_01_00, 6'b00_00_00, 6'b01_01_00, 6'b01_00_01, 6'b00_00_00};
        ew   = '{w(1,0,0,0), w(4,0,0,1), w(4,0,0,0), w(1,0,0,0), w(3,0,1,0), w(0,0,0,0)};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({ew[i], ew[i]});
            drive(stim[i]);
            begin
                logic [19:0] e = exp_q.pop_front();
                n_tests++;
                if (obs() !== e) begin
                    n_fail++; $display("FAIL nested beat %0d: got %h expected %h", i, obs(), e);
                end
            end
            if (i == 2) begin
                n_tests++;
                if (pc0[3:0] !== 4'd1) begin
                    n_fail++; $display("FAIL nested_cnt_after_err: got %0d expected 1", pc0[3:0]);
                end
            end
        end
        n_tests++;
        if ({ll0[3:0], pc0[3:0]} !== {4'd2, 4'd2}) begin
            n_fail++; $display("FAIL nested_len_cnt: got %h expected 22", {ll0[3:0], pc0[3:0]});
        end
    endtask

    task automatic test_stray_tail();
        logic [5:0] stim [5];
        logic [9:0] ew [5];
        stim = '{6'b01_00_01, 6'b00_00_00, 6'b01_01_00, 6'b01_00_01, 6'b00_00_00};
        ew   = '{w(4,0,0,1), w(4,0,0,0), w(1,0,0,0), w(3,0,1,0), w(0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({ew[i], ew[i]});
            drive(stim[i]);
            begin
                logic [19:0] e = exp_q.pop_front();
                n_tests++;
                if (obs() !== e) begin
                    n_fail++; $display("FAIL stray_tail beat %0d: got %h expected %h", i, obs(), e);
                end
            end
        end
        n_tests++;
        if ({ll0[3:0], pc0[3:0], pc1[7:4]} !== {4'd2, 4'd3, 4'd0}) begin
            n_fail++; $display("FAIL stray_len_cnt: got %h expected 230", {ll0[3:0], pc0[3:0], pc1[7:4]});
        end
    endtask

    task automatic test_overlength();
        logic [5:0] stim [10];
        logic [9:0] ew [10];
        stim = '{6'b10_10_00, 6'b10_00_00, 6'b10_00_00, 6'b10_00_00, 6'b00_00_00,
                 6'b10_10_00, 6'b10_00_00, 6'b10_00_00, 6'b10_00_10, 6'b00_00_00};
        ew   = '{w(0,1,0,0), w(0,2,0,0), w(0,2,0,0), w(0,4,0,2), w(0,4,0,0),
                 w(0,1,0,0), w(0,2,0,0), w(0,2,0,0), w(0,3,2,0), w(0,0,0,0)};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({ew[i], ew[i]});
            drive(stim[i]);
            begin
                logic [19:0] e = exp_q.pop_front();
                n_tests++;
                if (obs() !== e) begin
                    n_fail++; $display("FAIL overlength beat %0d: got %h expected %h", i, obs(), e);
                end
            end
        end
        n_tests++;
        if ({ll1[7:4], pc1[7:4], pc0[3:0]} !== {4'd4, 4'd1, 4'd3}) begin
            n_fail++; $display("FAIL overlength_len_cnt: got %h expected 413", {ll1[7:4], pc1[7:4], pc0[3:0]});
        end
    endtask

    task automatic pulse_clear(input string name);
        clear = 1'b1;
        exp_q.push_back('0);
        drive(6'b00_00_00);
        clear = 1'b0;
        begin
            logic [19:0] e = exp_q.pop_front();
            n_tests++;
            if ({obs(), ll1, ll0, pc1, pc0} !== {e, 32'h0}) begin
                n_fail++; $display("FAIL %s: got %h expected %h", name, {obs(), ll1, ll0, pc1, pc0}, {e, 32'h0});
            end
        end
    endtask

    task automatic test_single_beat();
        logic [9:0] e0 [4];
        logic [9:0] e1 [4];
        pulse_clear("single_pre_clear");
        e0 = '{w(1,0,0,0), w(4,0,0,1), w(1,0,0,0), w(2,0,0,0)};
        e1 = '{w(3,0,1,0), w(3,0,1,0), w(3,0,1,0), w(0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({e1[i], e0[i]});
            drive((i < 3) ? 6'b01_01_01 : 6'b00_00_00);
            begin
                logic [19:0] e = exp_q.pop_front();
                n_tests++;
                if (obs() !== e) begin
                    n_fail++; $display("FAIL single_beat cycle %0d: got %h expected %h", i, obs(), e);
                end
            end
        end
        n_tests++;
        if ({pc1[3:0], ll1[3:0], pc0[3:0], ll0[3:0]} !== {4'd3, 4'd1, 4'd0, 4'd0}) begin
            n_fail++; $display("FAIL single_beat_len_cnt: got %h expected 3100",
                               {pc1[3:0], ll1[3:0], pc0[3:0], ll0[3:0]});
        end
        pulse_clear("single_post_clear");
    endtask

    task automatic test_back_to_back_saturate();
        for (int k = 1; k <= 17; k++) begin
            exp_q.push_back({w(1,0,0,0), w(1,0,0,0)});
            exp_q.push_back({w(3,0,1,0), w(3,0,1,0)});
            for (int b = 0; b < 2; b++) begin
                drive(b == 0 ? 6'b01_01_00 : 6'b01_00_01);
                begin
                    logic [19:0] e = exp_q.pop_front();
                    n_tests++;
                    if (obs() !== e) begin
                        n_fail++; $display("FAIL b2b pkt %0d beat %0d: got %h expected %h", k, b, obs(), e);
                    end
                end
            end
            begin
                logic [3:0] ec = (k > 15) ? 4'd15 : 4'(k);
                n_tests++;
                if ({pc1[3:0], pc0[3:0], ll0[3:0]} !== {ec, ec, 4'd2}) begin
                    n_fail++; $display("FAIL b2b_cnt pkt %0d: got %h expected %h",
                                       k, {pc1[3:0], pc0[3:0], ll0[3:0]}, {ec, ec, 4'd2});
                end
            end
        end
        exp_q.push_back('0);
        drive(6'b00_00_00);
        begin
            logic [19:0] e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL b2b_idle: got %h expected %h", obs(), e);
            end
        end
        pulse_clear("saturate_clear");
    endtask

    task automatic test_async_reset();
        drive(6'b01_01_00);
        drive(6'b01_00_01);
        drive(6'b01_01_00);
        drive(6'b01_00_00);
        n_tests++;
        if ({st0[2:0], ll0[3:0], pc0[3:0]} !== {3'd2, 4'd2, 4'd1}) begin
            n_fail++; $display("FAIL async_pre: got %h expected 221", {st0[2:0], ll0[3:0], pc0[3:0]});
        end
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        n_tests++;
        if ({obs(), ll1, ll0, pc1, pc0} !== '0) begin
            n_fail++; $display("FAIL async_reset_immediate: got %h expected 0", {obs(), ll1, ll0, pc1, pc0});
        end
        #1 reset = 1'b0;
        exp_q.push_back('0);
        drive(6'b00_00_00);
        begin
            logic [19:0] e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL async_after_release: got %h expected %h", obs(), e);
            end
        end
        exp_q.push_back({w(1,0,0,0), w(1,0,0,0)});
        drive(6'b01_01_00);
        begin
            logic [19:0] e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL async_new_head: got %h expected %h", obs(), e);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_nested_head();
        test_stray_tail();
        test_overlength();
        test_single_beat();
        test_back_to_back_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
